// File: rtl/multdiv_iter_if.sv
// Request/response bundle between a pipeline stage and the iterative multiply/divide unit.
// Latency: none, wires only; the unit's timing is defined by multdiv_iter.
// Backpressure: the requester watches ready, and busy stalls the pipeline while an operation is in flight.
interface multdiv_iter_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             flush;
  logic             ready;
  logic             busy;
  logic             result_valid;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             exception;

  modport master (
    output start, op, operand_a, operand_b, flush,
    input  ready, busy, result_valid, result_lo, result_hi, exception
  );

  modport slave (
    input  start, op, operand_a, operand_b, flush,
    output ready, busy, result_valid, result_lo, result_hi, exception
  );
endinterface

// File: rtl/multdiv_iter.sv
// Iterative radix-2 multiplier/divider (signed/unsigned) with flush abort.
// Latency: result_valid WIDTH+1 clocks after accept, or 2 clocks for divide-by-zero.
// Backpressure: one op at a time; start is ignored unless ready, and busy stalls the pipeline.
module multdiv_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic          clock,
  input logic          reset,
  multdiv_iter_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t           state;
  state_t           state_nxt;

  // Latched operation context; the datapath works on magnitudes and fixes signs at the end.
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] opnd;
  logic [CNT_W-1:0] cnt;
  logic             is_div_q;
  logic             is_sgn_q;
  logic             neg_q_q;
  logic             neg_r_q;
  logic             div0_q;
  logic             ovf_q;

  logic [WIDTH-1:0] res_lo;
  logic [WIDTH-1:0] res_hi;
  logic             res_exc;

  logic             accept;
  logic             calc_last;
  logic             in_sgn;
  logic             a_neg;
  logic             b_neg;
  logic             in_div0;
  logic             in_min_ovf;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] hi_nxt;
  logic [WIDTH-1:0] lo_nxt;
  logic             unused_diff_msb;

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fin_lo;
  logic [WIDTH-1:0]   fin_hi;
  logic               fin_exc;

  // flush beats start in IDLE, so a redirect never launches a new op.
  assign accept    = (state == IDLE) && bus.start && !bus.flush;
  // Divide-by-zero spends a single CALC cycle with no iteration, giving its 2-clock result.
  assign calc_last = div0_q || (cnt == CNT_W'(WIDTH - 1));

  // Decode the incoming request into sign flags, magnitudes and special cases.
  always_comb begin
    in_sgn     = ~bus.op[0];
    a_neg      = in_sgn & bus.operand_a[WIDTH-1];
    b_neg      = in_sgn & bus.operand_b[WIDTH-1];
    a_mag      = a_neg ? -bus.operand_a : bus.operand_a;
    b_mag      = b_neg ? -bus.operand_b : bus.operand_b;
    in_div0    = bus.op[1] && (bus.operand_b == '0);
    in_min_ovf = bus.op[1] && in_sgn &&
                 (bus.operand_a == {1'b1, {(WIDTH-1){1'b0}}}) &&
                 (bus.operand_b == '1);
  end

  // One radix-2 step: shift-add for multiply, restoring subtract for divide.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opnd : {WIDTH{1'b0}})};
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, opnd};
    div_diff  = div_shift - {1'b0, opnd};
    hi_nxt    = acc_hi;
    lo_nxt    = acc_lo;
    if (!div0_q) begin
      if (is_div_q) begin
        // The partial remainder stays below the divisor, so its top bit is always zero.
        hi_nxt = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        lo_nxt = {acc_lo[WIDTH-2:0], div_ge};
      end else begin
        hi_nxt = mul_sum[WIDTH:1];
        lo_nxt = {mul_sum[0], acc_lo[WIDTH-1:1]};
      end
    end
  end

  assign unused_diff_msb = div_diff[WIDTH];

  // Apply signs to the final step's values and derive the exception flag.
  always_comb begin
    prod = {hi_nxt, lo_nxt};
    if (neg_q_q) begin
      prod = -prod;
    end
    fin_lo  = prod[WIDTH-1:0];
    fin_hi  = prod[2*WIDTH-1:WIDTH];
    fin_exc = is_sgn_q ? (fin_hi != {WIDTH{fin_lo[WIDTH-1]}}) : (fin_hi != '0);
    if (is_div_q) begin
      // MIN / -1 falls out naturally: |MIN| / 1 with no sign flip gives MIN, remainder 0.
      fin_lo  = neg_q_q ? -lo_nxt : lo_nxt;
      fin_hi  = neg_r_q ? -hi_nxt : hi_nxt;
      fin_exc = ovf_q;
      if (div0_q) begin
        fin_lo  = '0;
        fin_hi  = lo_nxt;
        fin_exc = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; flush aborts CALC, DONE always returns to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    if (bus.flush) state_nxt = IDLE;
               else if (calc_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs; a flush in DONE suppresses the pulse of the aborted op.
  always_comb begin
    bus.ready        = (state == IDLE);
    bus.busy         = (state != IDLE);
    bus.result_valid = (state == DONE) && !bus.flush;
  end

  // Operand capture, one iteration per CALC cycle, and result latch on the final step.
  always_ff @(posedge clock) begin
    if (!reset) begin
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd     <= '0;
      cnt      <= '0;
      is_div_q <= 1'b0;
      is_sgn_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      res_lo   <= '0;
      res_hi   <= '0;
      res_exc  <= 1'b0;
    end else if (accept) begin
      is_div_q <= bus.op[1];
      is_sgn_q <= in_sgn;
      neg_q_q  <= a_neg ^ b_neg;
      neg_r_q  <= a_neg;
      div0_q   <= in_div0;
      ovf_q    <= in_min_ovf;
      acc_hi   <= '0;
      acc_lo   <= bus.op[1] ? (in_div0 ? bus.operand_a : a_mag) : b_mag;
      opnd     <= bus.op[1] ? b_mag : a_mag;
      cnt      <= '0;
    end else if (bus.flush) begin
      cnt <= '0;
    end else if (state == CALC) begin
      acc_hi <= hi_nxt;
      acc_lo <= lo_nxt;
      if (!div0_q) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (calc_last) begin
        res_lo  <= fin_lo;
        res_hi  <= fin_hi;
        res_exc <= fin_exc;
      end
    end
  end

  assign bus.result_lo = res_lo;
  assign bus.result_hi = res_hi;
  assign bus.exception = res_exc;

endmodule

// File: tb/tb_multdiv_iter.sv
// Self-checking bench for multdiv_iter (WIDTH=32): directed vectors plus random traffic.
// An arithmetic reference model predicts result values, timing and handshake levels every cycle.
module tb_multdiv_iter;
  localparam int W = 32;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  multdiv_iter_if #(.WIDTH(W)) bus();
  multdiv_iter #(.WIDTH(W), .CNT_W(6)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state: cyc counts rising edges; done_cyc is the cycle in which DONE is visible.
  int          cyc = 0;
  bit          inflight = 1'b0;
  int          done_cyc = 0;
  bit          chk_en = 1'b0;
  logic [31:0] pend_lo, pend_hi, last_lo = '0, last_hi = '0;
  logic        pend_exc, last_exc = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Pure arithmetic reference: full-width products and truncating division via 64-bit integers.
  function automatic void ref_calc(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] lo, output logic [31:0] hi,
                                   output logic exc, output bit d0);
    logic [63:0] p;
    longint sa, sb;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    d0  = 1'b0;
    exc = 1'b0;
    lo  = '0;
    hi  = '0;
    case (op)
      2'b00: begin
        p = sa * sb;
        lo = p[31:0];
        hi = p[63:32];
        exc = (hi != {32{lo[31]}});
      end
      2'b01: begin
        p = {32'b0, a} * {32'b0, b};
        lo = p[31:0];
        hi = p[63:32];
        exc = (hi != 32'd0);
      end
      default: begin
        if (b == 32'd0) begin
          d0 = 1'b1; lo = '0; hi = a; exc = 1'b1;
        end else if (op == 2'b10 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          lo = a; hi = '0; exc = 1'b1;
        end else if (op == 2'b10) begin
          lo = 32'(sa / sb);
          hi = 32'(sa % sb);
        end else begin
          lo = a / b;
          hi = a % b;
        end
      end
    endcase
  endfunction

  // Model update at each rising edge, from the inputs the bench presented to that edge.
  always @(posedge clock) begin : model
    int e;
    logic [31:0] lo, hi;
    logic exc;
    bit d0;
    e = cyc + 1;
    if (!reset) begin
      inflight = 1'b0;
      last_lo = '0; last_hi = '0; last_exc = 1'b0;
      chk_en = 1'b1;
    end else if (inflight) begin
      if (bus.flush || cyc == done_cyc) inflight = 1'b0;
    end else if (bus.start && !bus.flush) begin
      ref_calc(bus.op, bus.operand_a, bus.operand_b, lo, hi, exc, d0);
      pend_lo = lo; pend_hi = hi; pend_exc = exc;
      inflight = 1'b1;
      done_cyc = e + (d0 ? 1 : W);
    end
    cyc = e;
    if (inflight && cyc == done_cyc) begin
      last_lo = pend_lo; last_hi = pend_hi; last_exc = pend_exc;
    end
  end

  // Every-cycle comparison of all outputs against the model, away from the active edge.
  always @(negedge clock) begin
    if (chk_en) begin
      chk("result_valid", bus.result_valid, inflight && (cyc == done_cyc) && !bus.flush);
      chk("ready", bus.ready, !inflight);
      chk("busy", bus.busy, inflight);
      chk("result_lo", bus.result_lo, last_lo);
      chk("result_hi", bus.result_hi, last_hi);
      chk("exception", bus.exception, last_exc);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(15));
      default: return $urandom;
    endcase
  endfunction

  // Launch one op from IDLE and check its latency and literal results; operands are scrambled after accept.
  task automatic directed(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] elo, input logic [31:0] ehi,
                          input logic eexc, input int elat);
    int e0;
    bit seen;
    seen = 1'b0;
    bus.start = 1'b1; bus.op = op; bus.operand_a = a; bus.operand_b = b;
    tick();
    e0 = cyc;
    bus.start = 1'b0; bus.op = 2'($urandom); bus.operand_a = $urandom; bus.operand_b = $urandom;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clock);
      if (bus.result_valid) begin
        seen = 1'b1;
        chk({name, " latency"}, 64'(cyc - e0 + 1), 64'(elat));
        chk({name, " lo"}, bus.result_lo, elo);
        chk({name, " hi"}, bus.result_hi, ehi);
        chk({name, " exc"}, bus.exception, eexc);
      end
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL %s timeout: result_valid not seen within 40 cycles", name);
    end
    tick();
  endtask

  initial begin
    logic [31:0] lo, hi;
    logic exc;
    bit d0;
    int e0;

    reset = 1'b0;
    bus.start = 1'b0; bus.flush = 1'b0; bus.op = 2'b00;
    bus.operand_a = '0; bus.operand_b = '0;
    repeat (3) tick();
    reset = 1'b1;
    tick();

    // Pin the reference model itself to hand-computed values.
    ref_calc(2'b00, 32'hFFFF_FFF9, 32'd6, lo, hi, exc, d0);
    chk("model smul lo", lo, 32'hFFFF_FFD6);
    chk("model smul hi", hi, 32'hFFFF_FFFF);
    ref_calc(2'b10, 32'hFFFF_FFEF, 32'd5, lo, hi, exc, d0);
    chk("model sdiv q", lo, 32'hFFFF_FFFD);
    chk("model sdiv r", hi, 32'hFFFF_FFFE);
    ref_calc(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lo, hi, exc, d0);
    chk("model umul", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

    // Directed vectors with literal expectations.
    directed("smul -7*6", 2'b00, 32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFD6, 32'hFFFF_FFFF, 1'b0, 33);
    directed("smul ovf", 2'b00, 32'h0001_0000, 32'h0001_0000, 32'd0, 32'd1, 1'b1, 33);
    directed("sdiv -17/5", 2'b10, 32'hFFFF_FFEF, 32'd5, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 1'b0, 33);
    directed("udiv by 0", 2'b11, 32'd9, 32'd0, 32'd0, 32'd9, 1'b1, 2);
    directed("sdiv min/-1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b1, 33);
    directed("umul max", 2'b01, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 32'd1, 1'b1, 33);
    directed("udiv 100/7", 2'b11, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);

    // Flush at edge 10 of a multiply, with a start attempt while busy; restart right after.
    bus.start = 1'b1; bus.op = 2'b01; bus.operand_a = 32'd1234; bus.operand_b = 32'd5678;
    tick();
    e0 = cyc;
    bus.start = 1'b0;
    repeat (3) tick();
    bus.start = 1'b1; bus.op = 2'b11; bus.operand_a = 32'd77; bus.operand_b = 32'd0;
    tick();
    bus.start = 1'b0;
    while (cyc < e0 + 9) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    @(negedge clock);
    chk("ready after flush", bus.ready, 1'b1);
    chk("busy after flush", bus.busy, 1'b0);
    directed("restart after flush", 2'b00, 32'd3, 32'hFFFF_FFFE, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 1'b0, 33);

    // flush together with start in IDLE: not accepted.
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = 2'b01; bus.operand_a = 32'd5; bus.operand_b = 32'd5;
    tick();
    bus.start = 1'b0; bus.flush = 1'b0;
    @(negedge clock);
    chk("flush+start ready", bus.ready, 1'b1);
    tick();

    // Reset at edge 15 of a divide, then an immediate new start.
    bus.start = 1'b1; bus.op = 2'b10; bus.operand_a = 32'd1000; bus.operand_b = 32'd3;
    tick();
    e0 = cyc;
    bus.start = 1'b0;
    while (cyc < e0 + 14) tick();
    reset = 1'b0;
    tick();
    @(negedge clock);
    chk("reset lo", bus.result_lo, 32'd0);
    chk("reset hi", bus.result_hi, 32'd0);
    chk("reset exc", bus.exception, 1'b0);
    chk("reset busy", bus.busy, 1'b0);
    chk("reset ready", bus.ready, 1'b1);
    reset = 1'b1;
    directed("start after reset", 2'b11, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 33);

    // Random traffic: starts while busy, operand churn, rare flush and reset.
    for (int n = 0; n < 5000; n++) begin
      bus.start     = ($urandom_range(99) < 35);
      bus.op        = 2'($urandom);
      bus.operand_a = pick();
      bus.operand_b = pick();
      bus.flush     = ($urandom_range(999) < 8);
      reset         = !($urandom_range(1999) == 0);
      tick();
    end
    bus.start = 1'b0; bus.flush = 1'b0; reset = 1'b1;
    repeat (40) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
